// File: rtl/sata_pstretch.sv
// Multi-channel programmable pulse stretcher for SATA link/PHY status strobes.
// Per-channel down-counters with RETRIG / ONESHOT (optional holdoff) / LEGACY modes.
module sata_pstretch #(
  parameter int NCH     = 4,
  parameter int LGLEN   = 4,
  parameter int HOLDOFF = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [LGLEN-1:0] i_len,
  input  logic [1:0]       i_mode,
  input  logic [NCH-1:0]   i_sig,
  output logic [NCH-1:0]   o_sig,
  output logic [NCH-1:0]   o_fall,
  output logic             o_any
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    MODE_RETRIG  = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_LEGACY  = 2'd2,
    MODE_RETRIG3 = 2'd3
  } mode_e;

  mode_e            mode;
  logic [LGLEN-1:0] load_len;
  logic [NCH-1:0]   sig_d, sig_q;
  logic [NCH-1:0]   fall_d, fall_q;
  logic             any_d, any_q;

  assign mode     = mode_e'(i_mode);
  // A zero length still produces a one-cycle pulse.
  assign load_len = (i_len == '0) ? LGLEN'(1) : i_len;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [LGLEN-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             hold_idle;
    logic             trig_os;

    assign trig_os = i_sig[k] & ~prev_q & (cnt_q == '0) & hold_idle;

    always_comb begin
      cnt_d = cnt_q;
      case (mode)
        MODE_ONESHOT: begin
          if (trig_os)
            cnt_d = load_len;
          else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        end
        MODE_LEGACY: begin
          if (cnt_q == '0) begin
            if (i_sig[k])
              cnt_d = load_len;
          end else if (cnt_q != LGLEN'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!i_sig[k]) begin
            cnt_d = '0;
          end
        end
        default: begin
          if (i_sig[k])
            cnt_d = load_len;
          else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        end
      endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        cnt_q  <= '0;
        prev_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        prev_q <= i_sig[k];
      end
    end

    if (HOLDOFF > 0) begin : g_hold
      logic [HW-1:0] hold_q, hold_d;

      // Holdoff only arms at the end of a ONESHOT pulse; it keeps draining in other modes.
      always_comb begin
        hold_d = hold_q;
        if (hold_q != '0)
          hold_d = hold_q - 1'b1;
        if (mode == MODE_ONESHOT && cnt_q == LGLEN'(1) && cnt_d == '0)
          hold_d = HW'(HOLDOFF);
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
          hold_q <= '0;
        else
          hold_q <= hold_d;
      end

      assign hold_idle = (hold_q == '0);
    end else begin : g_nohold
      assign hold_idle = 1'b1;
    end

    assign sig_d[k]  = (cnt_d != '0);
    assign fall_d[k] = sig_q[k] & ~sig_d[k];
  end

  assign any_d = |sig_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sig_q  <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign o_sig  = sig_q;
  assign o_fall = fall_q;
  assign o_any  = any_q;

endmodule

// File: tb/tb_sata_pstretch.sv
// Directed bench for sata_pstretch: hand-computed per-cycle windows for o_sig/o_fall/o_any.
module tb_sata_pstretch;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_len;
  logic [1:0] i_mode;
  logic [3:0] i_sig;
  logic [3:0] o_sig;
  logic [3:0] o_fall;
  logic       o_any;

  int n_total = 0;
  int n_bad   = 0;

  sata_pstretch #(.NCH(4), .LGLEN(4), .HOLDOFF(2)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_len  (i_len),
    .i_mode (i_mode),
    .i_sig  (i_sig),
    .o_sig  (o_sig),
    .o_fall (o_fall),
    .o_any  (o_any)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_sig = '0;
    repeat (n) tick();
  endtask

  function automatic logic [3:0] win(input int t, input int a, input int b, input logic [3:0] m);
    return (t >= a && t <= b) ? m : 4'b0000;
  endfunction

  task automatic chk_cycle(input string tag, input int t, input logic [3:0] es, input logic [3:0] ef);
    chk($sformatf("%s t%0d o_sig", tag, t), {28'd0, o_sig}, {28'd0, es});
    chk($sformatf("%s t%0d o_fall", tag, t), {28'd0, o_fall}, {28'd0, ef});
    chk($sformatf("%s t%0d o_any", tag, t), {31'd0, o_any}, {31'd0, |es});
  endtask

  initial begin
    i_reset = 1'b1;
    i_len   = '0;
    i_mode  = '0;
    i_sig   = '0;
    tick();
    tick();
    chk("reset o_sig", {28'd0, o_sig}, 32'd0);
    chk("reset o_fall", {28'd0, o_fall}, 32'd0);
    chk("reset o_any", {31'd0, o_any}, 32'd0);
    i_reset = 1'b0;
    idle(3);

    // RETRIG single trigger on ch0
    i_mode = 2'd0; i_len = 4'd4;
    for (int t = 0; t <= 7; t++) begin
      chk_cycle("retrig1", t, win(t, 1, 4, 4'b0001), win(t, 5, 5, 4'b0001));
      i_sig = (t == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    idle(4);

    // RETRIG re-trigger mid-pulse on ch1
    i_mode = 2'd0; i_len = 4'd3;
    for (int t = 0; t <= 8; t++) begin
      chk_cycle("retrig2", t, win(t, 1, 5, 4'b0010), win(t, 6, 6, 4'b0010));
      i_sig = (t == 0 || t == 2) ? 4'b0010 : 4'b0000;
      tick();
    end
    idle(4);

    // ONESHOT with holdoff=2 on ch2
    i_mode = 2'd1; i_len = 4'd2;
    for (int t = 0; t <= 12; t++) begin
      chk_cycle("oneshot", t, win(t, 1, 2, 4'b0100) | win(t, 7, 8, 4'b0100),
                win(t, 3, 3, 4'b0100) | win(t, 9, 9, 4'b0100));
      i_sig = (t <= 2 || t == 4 || (t >= 6 && t <= 9)) ? 4'b0100 : 4'b0000;
      tick();
    end
    idle(5);

    // LEGACY held input extends pulse
    i_mode = 2'd2; i_len = 4'd4;
    for (int t = 0; t <= 11; t++) begin
      chk_cycle("legacy_hold", t, win(t, 1, 8, 4'b0001), win(t, 9, 9, 4'b0001));
      i_sig = (t <= 7) ? 4'b0001 : 4'b0000;
      tick();
    end
    idle(3);

    // LEGACY with zero length gives one-cycle pulse
    i_mode = 2'd2; i_len = 4'd0;
    for (int t = 0; t <= 4; t++) begin
      chk_cycle("legacy_len0", t, win(t, 1, 1, 4'b0001), win(t, 2, 2, 4'b0001));
      i_sig = (t == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    idle(3);

    // LEGACY short input still gives the minimum length
    i_mode = 2'd2; i_len = 4'd3;
    for (int t = 0; t <= 6; t++) begin
      chk_cycle("legacy_min", t, win(t, 1, 3, 4'b1000), win(t, 4, 4, 4'b1000));
      i_sig = (t == 0) ? 4'b1000 : 4'b0000;
      tick();
    end
    idle(3);

    // All channels at max length
    i_mode = 2'd0; i_len = 4'd15;
    for (int t = 0; t <= 18; t++) begin
      chk_cycle("all_max", t, win(t, 1, 15, 4'b1111), win(t, 16, 16, 4'b1111));
      i_sig = (t == 0) ? 4'b1111 : 4'b0000;
      tick();
    end
    idle(3);

    // Mode 3 behaves as RETRIG
    i_mode = 2'd3; i_len = 4'd2;
    for (int t = 0; t <= 6; t++) begin
      chk_cycle("mode3", t, win(t, 1, 3, 4'b0010), win(t, 4, 4, 4'b0010));
      i_sig = (t <= 1) ? 4'b0010 : 4'b0000;
      tick();
    end
    idle(3);

    // Length change mid-pulse only affects later loads
    i_mode = 2'd0; i_len = 4'd5;
    for (int t = 0; t <= 7; t++) begin
      chk_cycle("len_change", t, win(t, 1, 5, 4'b0001), win(t, 6, 6, 4'b0001));
      i_sig = (t == 0) ? 4'b0001 : 4'b0000;
      if (t == 1) i_len = 4'd1;
      tick();
    end
    idle(3);

    // Reset mid-pulse
    i_mode = 2'd0; i_len = 4'd4;
    for (int t = 0; t <= 3; t++) begin
      chk_cycle("rst_mid", t, win(t, 1, 3, 4'b1000), 4'b0000);
      i_sig = (t == 0) ? 4'b1000 : 4'b0000;
      if (t < 3) tick();
    end
    i_reset = 1'b1;
    #1;
    chk("rst_mid async o_sig", {28'd0, o_sig}, 32'd0);
    chk("rst_mid async o_any", {31'd0, o_any}, 32'd0);
    chk("rst_mid async o_fall", {28'd0, o_fall}, 32'd0);
    tick();
    i_reset = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      chk_cycle("rst_after", t, 4'b0000, 4'b0000);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
